// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Hold/bubble/flush and PC-redirect controller for the 5-stage core.
// Revision : 1.0
// ============================================================================
module pipeline_ctrl #(
    parameter int FLUSH_CYCLES  = 2,
    parameter int STALL_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ctrl_jump_req_in,
    input  logic [31:0] ctrl_jump_addr_in,
    input  logic        ctrl_mem_busy_in,
    input  logic        ctrl_ex_is_load_in,
    input  logic [4:0]  ctrl_ex_write_addr_in,
    input  logic [4:0]  ctrl_id_reg1_addr_in,
    input  logic [4:0]  ctrl_id_reg2_addr_in,
    output logic        ctrl_hold_out,
    output logic        ctrl_bubble_out,
    output logic        ctrl_flush_out,
    output logic        ctrl_pc_jump_out,
    output logic [31:0] ctrl_pc_jump_addr_out,
    output logic        ctrl_timeout_out
);

    localparam int FCW = $clog2(FLUSH_CYCLES) + 1;
    localparam int SCW = $clog2(STALL_TIMEOUT + 1);
    localparam logic [FCW-1:0] c_FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
    localparam logic [SCW-1:0] c_STALL_MAX  = SCW'(STALL_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_FLUSH     = 2'd1,
        S_MEM_STALL = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [FCW-1:0] r_flush_cnt;
    logic [FCW-1:0] w_flush_cnt_nxt;
    logic [SCW-1:0] r_stall_cnt;
    logic [SCW-1:0] w_stall_cnt_nxt;
    logic           r_flush;
    logic           r_pc_jump;
    logic [31:0]    r_pc_jump_addr;
    logic           r_timeout;
    logic           w_accept;
    logic           w_hold;
    logic           w_bubble;
    logic           w_load_use;
    logic           w_timeout_hit;

    // x0 is hardwired to zero, so a load targeting it can never be a hazard.
    assign w_load_use = ctrl_ex_is_load_in
                      && (ctrl_ex_write_addr_in != 5'd0)
                      && ((ctrl_ex_write_addr_in == ctrl_id_reg1_addr_in)
                       || (ctrl_ex_write_addr_in == ctrl_id_reg2_addr_in));

    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_stall_cnt_nxt = r_stall_cnt;
        w_accept        = 1'b0;
        w_hold          = 1'b0;
        w_bubble        = 1'b0;
        case (r_state)
            S_RUN: begin
                if (ctrl_mem_busy_in) begin
                    w_hold          = 1'b1;
                    w_state_nxt     = S_MEM_STALL;
                    w_stall_cnt_nxt = SCW'(1);
                end else if (ctrl_jump_req_in) begin
                    w_accept = 1'b1;
                end else if (w_load_use) begin
                    w_hold   = 1'b1;
                    w_bubble = 1'b1;
                end
            end
            S_FLUSH: begin
                // Requests arriving here are from the wrong path and are dropped.
                if (ctrl_mem_busy_in) begin
                    w_hold = 1'b1;
                end else if (r_flush_cnt == '0) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_flush_cnt_nxt = r_flush_cnt - FCW'(1);
                end
            end
            S_MEM_STALL: begin
                if (ctrl_mem_busy_in) begin
                    w_hold = 1'b1;
                    if (r_stall_cnt < c_STALL_MAX) begin
                        w_stall_cnt_nxt = r_stall_cnt + SCW'(1);
                    end
                end else begin
                    w_state_nxt     = S_RUN;
                    w_stall_cnt_nxt = '0;
                    w_accept        = ctrl_jump_req_in;
                end
            end
            default: begin
                w_state_nxt     = S_RUN;
                w_flush_cnt_nxt = '0;
                w_stall_cnt_nxt = '0;
            end
        endcase
        if (w_accept) begin
            w_state_nxt     = S_FLUSH;
            w_flush_cnt_nxt = c_FLUSH_LOAD;
        end
    end

    assign w_timeout_hit = (w_state_nxt == S_MEM_STALL) && (w_stall_cnt_nxt == c_STALL_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_RUN;
            r_flush_cnt    <= '0;
            r_stall_cnt    <= '0;
            r_flush        <= 1'b0;
            r_pc_jump      <= 1'b0;
            r_pc_jump_addr <= '0;
            r_timeout      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_stall_cnt <= w_stall_cnt_nxt;
            r_flush     <= (w_state_nxt == S_FLUSH);
            r_pc_jump   <= w_accept;
            if (w_accept) begin
                r_pc_jump_addr <= ctrl_jump_addr_in;
            end
            if (w_timeout_hit) begin
                r_timeout <= 1'b1;
            end
        end
    end

    // Gate the combinational controls so they read 0 while reset is held.
    assign ctrl_hold_out         = rst & w_hold;
    assign ctrl_bubble_out       = rst & w_bubble;
    assign ctrl_flush_out        = r_flush;
    assign ctrl_pc_jump_out      = r_pc_jump;
    assign ctrl_pc_jump_addr_out = r_pc_jump_addr;
    assign ctrl_timeout_out      = r_timeout;

endmodule
`default_nettype wire
